fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the RISC-V core, directly upstream of `instructionmemory`. It owns the program counter and drives the memory's byte address. It captures the combinationally returned word into an IF/ID output register and hands it to decode over a valid/ready handshake. It also handles branch/jump redirects and flags fetches that are misaligned or out of range.

## Interface
Parameters:
- `WORD_SIZE`, 32: address/instruction width.
- `MEM_DEPTH`, 256: instruction memory depth in words; valid word indices are 0..MEM_DEPTH-1.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset. Must be word-aligned and in range.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `imem_addr`, out, WORD_SIZE: byte address to instruction memory; equals `pc` combinationally.
- `imem_instr`, in, WORD_SIZE: word returned by instruction memory in the same cycle.
- `redirect_valid`, in, 1: branch/jump taken this cycle.
- `redirect_pc`, in, WORD_SIZE: redirect target byte address.
- `out_valid`, out, 1: IF/ID entry valid; equals `valid_q & ~redirect_valid`.
- `out_ready`, in, 1: decode accepts the entry.
- `out_instr`, out, WORD_SIZE: fetched instruction.
- `out_pc`, out, WORD_SIZE: byte address of `out_instr`.
- `fetch_fault`, out, 1: unit is in FAULT state.
- `fault_pc`, out, WORD_SIZE: offending address latched on fault entry.
- `perf_fetched`, out, 32: accepted handshakes, saturating.
- `perf_stall`, out, 32: cycles in which `valid_q & ~out_ready`, saturating.

## Operation
- State machine has two states:
  - RUN: fetching.
  - FAULT: not fetching; waits for a redirect.
- Address check: `pc` is bad if `pc[1:0] != 0` or `pc[WORD_SIZE-1:2] >= MEM_DEPTH`.
- `load` = RUN & ~redirect_valid & pc good & (~valid_q | out_ready).
- On `load`:
  - `out_instr <= imem_instr`, `out_pc <= pc`, `valid_q <= 1`.
  - `pc <= pc + 4`, wrapping modulo 2^WORD_SIZE. Wrap-around lands in range-check, so the next cycle faults unless 2^30 ≤ MEM_DEPTH.
- Drain without reload: when `valid_q & out_ready` and no load occurs, `valid_q <= 0`.
- Bad pc while in RUN with no redirect: go to FAULT, `fault_pc <= pc`, no load, held entry unaffected (it may still drain).
- Redirect (highest priority, any state):
  - `pc <= redirect_pc`, `valid_q <= 0` (squash).
  - State goes to RUN. If `redirect_pc` is bad, the next cycle enters FAULT per the rule above.
  - `out_valid` is masked low in the redirect cycle, so no handshake completes then.
- In FAULT, `imem_addr` still equals `pc`; `imem_instr` is ignored.
- Stall: while `valid_q & ~out_ready`, `out_instr`, `out_pc` and `pc` hold stable.

## Timing
- Reset values (asynchronous):
  - `pc = RESET_PC`, `valid_q = 0`, state RUN.
  - `out_instr = 0`, `out_pc = 0`, `fault_pc = 0`, `fetch_fault = 0`, perf counters 0.
- Latency: the first `out_valid` is seen 1 cycle after reset deasserts. With `out_ready` held high, throughput is one instruction per cycle.
- Redirect penalty: the redirect is asserted at edge N. The target instruction is valid after edge N+1, i.e. 1 bubble.
- Fault: `fetch_fault` rises 1 cycle after a bad `pc` is presented. It clears the cycle after a redirect edge.
- Reset asserted mid-operation: all state clears immediately. Any in-flight entry is lost.
- No combinational path from `out_ready` to `imem_addr`. There is a combinational path from `redirect_valid` to `out_valid`.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `perf_fetched` increments on each `out_valid & out_ready` cycle.
  - `perf_stall` increments on each `valid_q & ~out_ready` cycle.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: no counter flops; both outputs are tied to 0. Ports remain present.

## Test plan
- Reset with `RESET_PC=0` and `out_ready=1`; memory words 0..3 = 0x11,0x22,0x33,0x44 → after reset release, `out_pc` reads 0,4,8,12 on consecutive cycles with the matching instructions and no gaps.
- `out_ready=0` for 3 cycles while `out_pc=8` → `out_pc`/`out_instr` held at 8/0x33, `pc` stays 12, `perf_stall` increases by 3 (macro on).
- Redirect to 0x40 while an entry is held with `out_ready=1` → `out_valid=0` that cycle; the next valid entry has `out_pc=0x40`; `perf_fetched` is not incremented for the squashed entry.
- Redirect to 0x42 → `fetch_fault=1` and `fault_pc=0x42` two edges later, no further `out_valid`. A later redirect to 0x8 → fault clears and an entry with `out_pc=0x8` follows.
- Sequential fetch reaching `pc = 4*MEM_DEPTH` (0x400) → fault with `fault_pc=0x400`; the last delivered entry has `out_pc=0x3FC`.
- Assert `rst_n=0` mid-stream during a stall → `out_valid`, `fetch_fault` and counters go to 0 immediately; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: RISC-V instruction-fetch stage owning the PC, the IF/ID register and redirect/fault handling.
// Define FETCH_PERF_CNT_EN to build the saturating perf_fetched / perf_stall counters; otherwise both read 0.
module fetch_unit #(
  parameter int unsigned          WORD_SIZE = 32,
  parameter int unsigned          MEM_DEPTH = 256,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic [WORD_SIZE-1:0] imem_instr,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_instr,
  output logic [WORD_SIZE-1:0] out_pc,
  output logic                 fetch_fault,
  output logic [WORD_SIZE-1:0] fault_pc,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_stall
);

  typedef enum logic {ST_RUN = 1'b0, ST_FAULT = 1'b1} state_e;

  localparam logic [WORD_SIZE-1:0] DEPTH_W = WORD_SIZE'(MEM_DEPTH);
  localparam logic [WORD_SIZE-1:0] PC_STEP = WORD_SIZE'(4);

  state_e               r_state, w_state_nxt;
  logic [WORD_SIZE-1:0] r_pc, w_pc_nxt;
  logic [WORD_SIZE-1:0] r_out_instr, r_out_pc, r_fault_pc;
  logic                 r_valid_q, w_valid_nxt;
  logic                 w_pc_bad, w_load, w_fault_entry, w_drain;

  // Word index compared zero-extended so any WORD_SIZE works against the depth.
  assign w_pc_bad      = (r_pc[1:0] != 2'b00) || ({2'b00, r_pc[WORD_SIZE-1:2]} >= DEPTH_W);
  assign w_fault_entry = (r_state == ST_RUN) & ~redirect_valid & w_pc_bad;
  assign w_load        = (r_state == ST_RUN) & ~redirect_valid & ~w_pc_bad & (~r_valid_q | out_ready);
  assign w_drain       = r_valid_q & out_ready;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid_q;
    if (redirect_valid) begin
      w_state_nxt = ST_RUN;
      w_pc_nxt    = redirect_pc;
      w_valid_nxt = 1'b0;
    end else if (w_fault_entry) begin
      w_state_nxt = ST_FAULT;
      if (w_drain) w_valid_nxt = 1'b0;
    end else if (w_load) begin
      w_pc_nxt    = r_pc + PC_STEP;
      w_valid_nxt = 1'b1;
    end else if (w_drain) begin
      w_valid_nxt = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_PC;
      r_valid_q   <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
      r_fault_pc  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_valid_q <= w_valid_nxt;
      if (w_load) begin
        r_out_instr <= imem_instr;
        r_out_pc    <= r_pc;
      end
      if (w_fault_entry) r_fault_pc <= r_pc;
    end
  end

  assign imem_addr   = r_pc;
  assign out_valid   = r_valid_q & ~redirect_valid;
  assign out_instr   = r_out_instr;
  assign out_pc      = r_out_pc;
  assign fetch_fault = (r_state == ST_FAULT);
  assign fault_pc    = r_fault_pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched, r_perf_stall;
  logic        w_accept, w_stall;

  assign w_accept = out_valid & out_ready;
  assign w_stall  = r_valid_q & ~out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_accept && (r_perf_fetched != '1)) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_stall && (r_perf_stall != '1))    r_perf_stall   <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`else
  assign perf_fetched = '0;
  assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus for fetch_unit, checked every cycle against a behavioural model
// plus hand-computed literal expectations at the interesting points.
module tb_fetch_unit;

  localparam int unsigned DEPTH  = 256;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_instr, redirect_pc;
  logic        redirect_valid, out_valid, out_ready, fetch_fault;
  logic [31:0] out_instr, out_pc, fault_pc, perf_fetched, perf_stall;

  logic [31:0] mem [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[9:2]];

  fetch_unit #(.WORD_SIZE(32), .MEM_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fetch_fault   (fetch_fault),
    .fault_pc      (fault_pc),
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one held instruction slot, a PC, and fault/counter bookkeeping.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] opc;
    logic [31:0] fault_pc;
    logic [31:0] fetched;
    logic [31:0] stall;
    logic        valid;
    logic        fault;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r     = '0;
    r.pc  = RST_PC;
    return r;
  endfunction

  function automatic model_t model_step(input model_t m, input logic redir,
                                        input logic [31:0] rpc, input logic rdy);
    model_t n;
    logic   bad, taken;
    n     = m;
    bad   = (m.pc % 4 != 0) || (m.pc / 4 >= DEPTH);
    taken = m.valid && !redir && rdy;
    if (taken && m.fetched != 32'hFFFF_FFFF) n.fetched = m.fetched + 1;
    if (m.valid && !rdy && m.stall != 32'hFFFF_FFFF) n.stall = m.stall + 1;
    if (redir) begin
      n.pc    = rpc;
      n.valid = 1'b0;
      n.fault = 1'b0;
    end else if (!m.fault && bad) begin
      n.fault    = 1'b1;
      n.fault_pc = m.pc;
      if (taken) n.valid = 1'b0;
    end else if (!m.fault && (!m.valid || rdy)) begin
      n.instr = mem[m.pc[9:2]];
      n.opc   = m.pc;
      n.valid = 1'b1;
      n.pc    = m.pc + 4;
    end else if (taken) begin
      n.valid = 1'b0;
    end
    return n;
  endfunction

  model_t mdl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdl <= model_reset();
    else        mdl <= model_step(mdl, redirect_valid, redirect_pc, out_ready);
  end

  // Every-cycle comparison, on the falling edge while inputs are stable.
  always @(negedge clk) begin
    check("m_imem_addr", imem_addr, mdl.pc);
    check("m_out_valid", {31'b0, out_valid}, {31'b0, mdl.valid && !redirect_valid});
    if (mdl.valid) begin
      check("m_out_pc", out_pc, mdl.opc);
      check("m_out_instr", out_instr, mdl.instr);
    end
    check("m_fetch_fault", {31'b0, fetch_fault}, {31'b0, mdl.fault});
    if (mdl.fault) check("m_fault_pc", fault_pc, mdl.fault_pc);
`ifdef FETCH_PERF_CNT_EN
    check("m_perf_fetched", perf_fetched, mdl.fetched);
    check("m_perf_stall", perf_stall, mdl.stall);
`else
    check("m_perf_fetched_off", perf_fetched, 32'h0);
    check("m_perf_stall_off", perf_stall, 32'h0);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input string name, input logic [31:0] pc, input logic [31:0] instr);
    check({name, "_valid"}, {31'b0, out_valid}, 32'h1);
    check({name, "_pc"}, out_pc, pc);
    check({name, "_instr"}, out_instr, instr);
  endtask

  initial begin
    logic [31:0] last_pc;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_fault", {31'b0, fetch_fault}, 32'h0);

    // Back-to-back fetch after reset release.
    rst_n = 1'b1;
    step(); expect_entry("seq0", 32'h0, 32'h11);
    step(); expect_entry("seq1", 32'h4, 32'h22);
    step(); expect_entry("seq2", 32'h8, 32'h33);
    check("seq2_pc", imem_addr, 32'hC);

    // Three-cycle stall holds the entry and the PC.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_entry("stall", 32'h8, 32'h33);
      check("stall_pc", imem_addr, 32'hC);
    end
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt", perf_stall, 32'd3);
`endif

    // Redirect squashes the held entry; no handshake in the redirect cycle.
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    check("redir_mask", {31'b0, out_valid}, 32'h0);
    step(); redirect_valid = 1'b0;
    check("redir_bubble", {31'b0, out_valid}, 32'h0);
    check("redir_pc", imem_addr, 32'h40);
    step(); expect_entry("redir_tgt", 32'h40, 32'hA500_0010);
`ifdef FETCH_PERF_CNT_EN
    check("redir_fetched", perf_fetched, 32'd2);
`endif

    // Misaligned redirect target faults two edges after the redirect.
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step(); redirect_valid = 1'b0;
    check("mis_nofault_yet", {31'b0, fetch_fault}, 32'h0);
    step();
    check("mis_fault", {31'b0, fetch_fault}, 32'h1);
    check("mis_fault_pc", fault_pc, 32'h42);
    step();
    check("mis_no_valid", {31'b0, out_valid}, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    step(); redirect_valid = 1'b0;
    check("mis_clear", {31'b0, fetch_fault}, 32'h0);
    step(); expect_entry("recover", 32'h8, 32'h33);

    // Running off the end of memory.
    redirect_valid = 1'b1; redirect_pc = 32'h3F0;
    step(); redirect_valid = 1'b0;
    last_pc = 32'hFFFF_FFFF;
    for (int k = 0; k < 20 && !fetch_fault; k++) begin
      step();
      if (out_valid) last_pc = out_pc;
    end
    check("end_fault", {31'b0, fetch_fault}, 32'h1);
    check("end_fault_pc", fault_pc, 32'h400);
    check("end_last_pc", last_pc, 32'h3FC);
    check("end_no_valid", {31'b0, out_valid}, 32'h0);

    // Asynchronous reset during a stall.
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step(); redirect_valid = 1'b0;
    step(); out_ready = 1'b0;
    step(); step();
    expect_entry("pre_rst", 32'h10, 32'hA500_0004);
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, out_valid}, 32'h0);
    check("arst_fault", {31'b0, fetch_fault}, 32'h0);
    check("arst_pc", imem_addr, RST_PC);
    check("arst_fetched", perf_fetched, 32'h0);
    check("arst_stall", perf_stall, 32'h0);
    out_ready = 1'b1;
    step(); rst_n = 1'b1;
    step(); expect_entry("restart0", 32'h0, 32'h11);
    step(); expect_entry("restart1", 32'h4, 32'h22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
